afifo_push_arbiter: RTL and testbench
=====================================

# afifo_push_arbiter

Round-robin arbiter that shares the write (push) port of the asynchronous FIFO among `NumReq` write-domain requesters. It sits entirely in the `Wclk` domain, between the requesters and the FIFO's `Push`/`DataIn`/`full` pins. The grant is held for bounded bursts so one requester's consecutive beats stay contiguous in the FIFO. It never pushes while `full` is high.

## Interface
Parameters:
- `DataSize`, 3: FIFO data width, matching the FIFO instance.
- `NumReq`, 4: number of requesters. Legal range is 2 to 16.
- `MaxBurst`, 4: maximum beats accepted per grant. Legal range is 1 to 16.
- `IdWidth`, derived as `$clog2(NumReq)` (local): requester index width.

Ports:
- `Wclk`, in, 1: write-domain clock. All logic is on its rising edge.
- `Wresetn`, in, 1: asynchronous, active-low reset. Assertion is asynchronous; deassertion is sampled on `Wclk`.
- `Req`, in, `NumReq`: per-requester "has a beat" flag. It must hold with its data until `Ack`.
- `ReqData`, in, `NumReq*DataSize`: packed data. Requester i occupies `[i*DataSize +: DataSize]`.
- `Ack`, out, `NumReq`: one-hot, combinational. The beat of requester i is consumed in this cycle.
- `full`, in, 1: FIFO full flag (write domain).
- `Push`, out, 1: FIFO push strobe, combinational.
- `DataIn`, out, `DataSize`: FIFO write data. It is the owner's `ReqData` slice.
- `Grant`, out, `NumReq`: registered one-hot owner. All zeros when idle.
- `OwnerId`, out, `IdWidth`: registered owner index. It reads 0 when idle.
- `Busy`, out, 1: registered. High when state is OWN.

## Operation
State machine with two states, IDLE and OWN.

Registers:
- `state`
- `owner`
- `LastOwner`: the previous owner, used as the round-robin pointer
- `beat`: burst counter, `$clog2(MaxBurst+1)` bits

Round-robin pick:
- The winner is the first asserted `Req` scanning `LastOwner+1, LastOwner+2, …`, wrapping modulo `NumReq`.
- The scan includes `LastOwner` itself last.

Beat condition: `Push = (state==OWN) & Req[owner] & !full`.
- `Ack[owner] = Push`. All other `Ack` bits are 0.
- `DataIn` is the owner's slice whenever state is OWN, and 0 in IDLE.

Transitions:
- IDLE → OWN when `|Req`. The owner is the pick, and `beat` is set to 0.
- OWN → release when either of these holds:
  - a beat occurs with `beat == MaxBurst-1`, or
  - `Req[owner]==0`, which counts as the requester abandoning its burst. The release happens in the same cycle `Req[owner]` drops.
- On release, `LastOwner` is set to `owner`. If any `Req` bit other than the departing owner's is set, the block re-arbitrates immediately and stays in OWN with the new pick. Otherwise it goes to IDLE.
- OWN with `Req[owner]` high and `full` high: stall. State, `owner` and `beat` are all held. There is no timeout.
- On a beat without release, `beat` increments by 1.

Reset values (asynchronous):
- state IDLE
- `owner` 0
- `LastOwner` = `NumReq-1`, so requester 0 has first priority
- `beat` 0
- `Grant` 0, `OwnerId` 0, `Busy` 0
- `Push`, `Ack` and `DataIn` are 0 because state is IDLE.

Reset mid-burst: a partially accepted burst is abandoned. No `Push` is issued while `Wresetn` is low.

## Timing
- Arbitration is registered. The earliest `Push` comes 1 cycle after `Req` rises from IDLE.
- Back-to-back owners: after a release, the new owner's first beat can come in the very next cycle, so there is no bubble cycle.
- Steady state is one beat per cycle per grant while `!full`.
- A beat is consumed on the `Wclk` edge where `Push & !full`. `full` rising deasserts `Push` in the same cycle.
- `Grant`, `OwnerId` and `Busy` change only on `Wclk` edges or on asynchronous reset.

Invariants (assertion targets for the verifier):
- `Push` → `!full`
- `$onehot0(Grant)` and `$onehot0(Ack)`
- `Ack` is a subset of `Grant`
- `Push == |Ack`
- at most `MaxBurst` consecutive `Ack` to the same requester per grant
- any requester holding `Req` is granted within `(NumReq-1)*(MaxBurst+1)+1` cycles of non-full operation

## Structure
- Shared package `afifo_pkg`:
  - arbiter state enum (IDLE, OWN)
  - the `IdWidth` computation helper
  - the round-robin pick function (request vector, last index → index and valid)
- Sub-module `rr_pick`: purely combinational priority rotate. It is instantiated once and is reusable for the read-side pop arbiter.
- The top module holds the FSM, counters and output muxing.

## Test plan
- Single requester, `Req[2]=1` for 6 beats, data 1..6, `MaxBurst=4`, `full=0`:
  - `Push` 4 cycles (data 1–4)
  - re-grant to 2 with no other requesters
  - `Push` 2 cycles (data 5–6)
  - FIFO contents 1..6 in order.
- All four requesters hold `Req` continuously:
  - grants rotate 0,1,2,3,0 (reset pointer is 3), each for exactly 4 `Ack` beats
  - no idle cycle between owners.
- `full` high for 3 cycles mid-burst of requester 1 at `beat=2`:
  - `Push=0` and `Ack=0` for those 3 cycles, `Grant` stays 1
  - the burst resumes and completes 2 more beats.
- Requester 0 drops `Req` after 1 beat while `Req[3]=1`:
  - release in that cycle
  - `Grant` becomes `0b1000` next cycle
  - `LastOwner=0`.
- `Wresetn` pulsed low asynchronously mid-burst (between edges):
  - `Push`, `Ack`, `Grant` and `Busy` go to 0 immediately
  - after release, the first grant goes to requester 0 if it is requesting.

Source files
------------

// File: rtl/afifo_push_arbiter_pkg.sv
// Shared definitions for the async FIFO push/pop arbiters: arbiter states,
// index-width helper and the round-robin pick used by rr_pick.
package afifo_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arbState_e;

    localparam int MaxReq = 16;

    function automatic int idWidth(input int numReq);
        return (numReq < 2) ? 1 : $clog2(numReq);
    endfunction

    // Returns {valid, index}; scans last+1, last+2, ... and reaches last itself at the end.
    function automatic logic [4:0] rrPick(input logic [MaxReq-1:0] req,
                                          input logic [3:0]        last,
                                          input int                numReq);
        logic [4:0] result;
        int         idx;
        result = '0;
        for (int k = numReq; k >= 1; k--) begin
            idx = (int'(last) + k) % numReq;
            if (req[idx]) begin
                result = {1'b1, 4'(idx)};
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/afifo_push_arbiter_if.sv
// Requester/FIFO-facing bundle of the push arbiter; the arbiter uses the
// slave modport, the requesters plus FIFO side use master.
interface afifo_push_arbiter_if #(
    parameter int DataSize = 3,
    parameter int NumReq   = 4,
    parameter int IdWidth  = 2
);
    logic [NumReq-1:0]          Req;
    logic [NumReq*DataSize-1:0] ReqData;
    logic [NumReq-1:0]          Ack;
    logic                       full;
    logic                       Push;
    logic [DataSize-1:0]        DataIn;
    logic [NumReq-1:0]          Grant;
    logic [IdWidth-1:0]         OwnerId;
    logic                       Busy;

    modport master (
        output Req, ReqData, full,
        input  Ack, Push, DataIn, Grant, OwnerId, Busy
    );

    modport slave (
        input  Req, ReqData, full,
        output Ack, Push, DataIn, Grant, OwnerId, Busy
    );
endinterface

// File: rtl/afifo_push_arbiter_rr_pick.sv
// Purely combinational round-robin priority rotate; shared by the push and
// pop arbiters.
module rr_pick
    import afifo_pkg::*;
#(
    parameter int NumReq  = 4,
    parameter int IdWidth = idWidth(NumReq)
) (
    input  logic [NumReq-1:0]  i_req,
    input  logic [IdWidth-1:0] i_last,
    output logic [IdWidth-1:0] o_idx,
    output logic               o_valid
);
    logic [4:0] w_pick;

    assign w_pick  = rrPick(MaxReq'(i_req), 4'(i_last), NumReq);
    assign o_valid = w_pick[4];
    assign o_idx   = IdWidth'(w_pick[3:0]);
endmodule

// File: rtl/afifo_push_arbiter.sv
// Round-robin arbiter sharing the async FIFO write port among NumReq
// write-domain requesters, holding each grant for bursts of up to MaxBurst beats.
module afifo_push_arbiter
    import afifo_pkg::*;
#(
    parameter int DataSize = 3,
    parameter int NumReq   = 4,
    parameter int MaxBurst = 4
) (
    input  logic          Wclk,
    input  logic          Wresetn,
    afifo_push_arbiter_if.slave bus
);
    localparam int IdWidth   = idWidth(NumReq);
    localparam int BeatWidth = $clog2(MaxBurst + 1);

    arbState_e            r_state;
    logic [IdWidth-1:0]   r_owner;
    logic [IdWidth-1:0]   r_lastOwner;
    logic [BeatWidth-1:0] r_beat;
    logic [NumReq-1:0]    r_grant;
    logic [IdWidth-1:0]   r_ownerId;
    logic                 r_busy;

    logic                 w_own;
    logic                 w_ownReq;
    logic                 w_push;
    logic                 w_release;
    logic [NumReq-1:0]    w_pickReq;
    logic [IdWidth-1:0]   w_pickLast;
    logic [IdWidth-1:0]   w_pickIdx;
    logic                 w_pickValid;

    assign w_own     = (r_state == OWN);
    assign w_ownReq  = bus.Req[r_owner];
    assign w_push    = w_own & w_ownReq & ~bus.full;
    assign w_release = w_own & (~w_ownReq | (w_push & (r_beat == BeatWidth'(MaxBurst - 1))));

    // While owning, the departing owner is masked so a release only re-arbitrates to someone else.
    assign w_pickReq  = w_own ? (bus.Req & ~(NumReq'(1) << r_owner)) : bus.Req;
    assign w_pickLast = w_own ? r_owner : r_lastOwner;

    rr_pick #(
        .NumReq  (NumReq),
        .IdWidth (IdWidth)
    ) u_rrPick (
        .i_req   (w_pickReq),
        .i_last  (w_pickLast),
        .o_idx   (w_pickIdx),
        .o_valid (w_pickValid)
    );

    assign bus.Push    = w_push;
    assign bus.Ack     = w_push ? (NumReq'(1) << r_owner) : '0;
    assign bus.DataIn  = w_own ? bus.ReqData[int'(r_owner)*DataSize +: DataSize] : '0;
    assign bus.Grant   = r_grant;
    assign bus.OwnerId = r_ownerId;
    assign bus.Busy    = r_busy;

    always_ff @(posedge Wclk or negedge Wresetn) begin
        if (!Wresetn) begin
            r_state     <= IDLE;
            r_owner     <= '0;
            r_lastOwner <= IdWidth'(NumReq - 1);
            r_beat      <= '0;
            r_grant     <= '0;
            r_ownerId   <= '0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pickValid) begin
                        r_state   <= OWN;
                        r_owner   <= w_pickIdx;
                        r_beat    <= '0;
                        r_grant   <= NumReq'(1) << w_pickIdx;
                        r_ownerId <= w_pickIdx;
                        r_busy    <= 1'b1;
                    end
                end
                OWN: begin
                    if (w_release) begin
                        r_lastOwner <= r_owner;
                        if (w_pickValid) begin
                            r_owner   <= w_pickIdx;
                            r_beat    <= '0;
                            r_grant   <= NumReq'(1) << w_pickIdx;
                            r_ownerId <= w_pickIdx;
                        end else begin
                            r_state   <= IDLE;
                            r_beat    <= '0;
                            r_grant   <= '0;
                            r_ownerId <= '0;
                            r_busy    <= 1'b0;
                        end
                    end else if (w_push) begin
                        r_beat <= r_beat + BeatWidth'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_afifo_push_arbiter.sv
// Self-checking bench for afifo_push_arbiter: directed scenarios with literal
// expectations, then randomized traffic against a behavioural arbitration model.
module tb_afifo_push_arbiter;
    localparam int DataSize = 3;
    localparam int NumReq   = 4;
    localparam int MaxBurst = 4;

    logic Wclk = 1'b0;
    logic Wresetn;

    afifo_push_arbiter_if #(.DataSize(DataSize), .NumReq(NumReq), .IdWidth(2)) bus ();

    afifo_push_arbiter #(
        .DataSize (DataSize),
        .NumReq   (NumReq),
        .MaxBurst (MaxBurst)
    ) dut (
        .Wclk    (Wclk),
        .Wresetn (Wresetn),
        .bus     (bus)
    );

    initial forever #5 Wclk = ~Wclk;

    int checkCount = 0;
    int errorCount = 0;

    // Requester agents: beats still to send and the data of the current beat.
    int                  remaining [NumReq];
    logic [DataSize-1:0] nextData  [NumReq];

    // Behavioural model: who owns the port, the round-robin pointer, beats taken this grant.
    bit mBusy;
    int mOwner;
    int mLast;
    int mBeats;

    logic                expPush;
    logic [NumReq-1:0]   reqNow;
    logic                obsPush;
    logic [NumReq-1:0]   obsAck;
    logic [NumReq-1:0]   obsGrant;
    logic [1:0]          obsOwner;
    logic [DataSize-1:0] dutFifo[$];

    task automatic checkValue(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic int pickModel(input logic [NumReq-1:0] req, input int last);
        for (int k = 1; k <= NumReq; k++) begin
            if (req[(last + k) % NumReq]) return (last + k) % NumReq;
        end
        return -1;
    endfunction

    task automatic modelReset();
        mBusy  = 1'b0;
        mOwner = 0;
        mLast  = NumReq - 1;
        mBeats = 0;
    endtask

    task automatic applyStimulus(input logic fullIn);
        for (int i = 0; i < NumReq; i++) begin
            bus.Req[i] = (remaining[i] > 0);
            bus.ReqData[i*DataSize +: DataSize] = nextData[i];
        end
        bus.full = fullIn;
    endtask

    task automatic checkOutput();
        logic [NumReq-1:0]   expAck;
        logic [NumReq-1:0]   expGrant;
        logic [DataSize-1:0] expData;
        reqNow   = bus.Req;
        expPush  = mBusy && reqNow[mOwner] && !bus.full;
        expAck   = expPush ? (NumReq'(1) << mOwner) : '0;
        expGrant = mBusy ? (NumReq'(1) << mOwner) : '0;
        expData  = mBusy ? nextData[mOwner] : '0;
        checkValue("Push", 32'(bus.Push), 32'(expPush));
        checkValue("Ack", 32'(bus.Ack), 32'(expAck));
        checkValue("DataIn", 32'(bus.DataIn), 32'(expData));
        checkValue("Grant", 32'(bus.Grant), 32'(expGrant));
        checkValue("OwnerId", 32'(bus.OwnerId), mBusy ? 32'(mOwner) : 32'd0);
        checkValue("Busy", 32'(bus.Busy), 32'(mBusy));
        obsPush  = bus.Push;
        obsAck   = bus.Ack;
        obsGrant = bus.Grant;
        obsOwner = bus.OwnerId;
        if (bus.Push === 1'b1) dutFifo.push_back(bus.DataIn);
    endtask

    // Effect of the coming clock edge on the requesters and on the model.
    task automatic stepModel();
        logic [NumReq-1:0] others;
        int                oldOwner;
        oldOwner = mOwner;
        if (expPush) begin
            remaining[oldOwner]--;
            nextData[oldOwner]++;
            mBeats++;
        end
        if (!mBusy) begin
            if (reqNow != '0) begin
                mOwner = pickModel(reqNow, mLast);
                mBusy  = 1'b1;
                mBeats = 0;
            end
        end else if ((expPush && mBeats == MaxBurst) || !reqNow[mOwner]) begin
            mLast  = mOwner;
            others = reqNow;
            others[mOwner] = 1'b0;
            if (others != '0) begin
                mOwner = pickModel(others, mLast);
                mBeats = 0;
            end else begin
                mBusy  = 1'b0;
                mBeats = 0;
            end
        end
    endtask

    task automatic runCycle(input logic fullIn);
        applyStimulus(fullIn);
        #4;
        checkOutput();
        stepModel();
        @(posedge Wclk);
        #1;
    endtask

    task automatic clearRequests();
        for (int i = 0; i < NumReq; i++) remaining[i] = 0;
    endtask

    task automatic doReset();
        Wresetn = 1'b0;
        modelReset();
        @(posedge Wclk);
        #1;
        Wresetn = 1'b1;
        dutFifo.delete();
    endtask

    initial begin
        logic [7:0] pushHist;

        Wresetn = 1'b0;
        clearRequests();
        for (int i = 0; i < NumReq; i++) nextData[i] = '0;
        applyStimulus(1'b0);
        modelReset();
        #7;
        checkValue("resetGrant", 32'(bus.Grant), 32'd0);
        checkValue("resetBusy", 32'(bus.Busy), 32'd0);
        checkValue("resetOwnerId", 32'(bus.OwnerId), 32'd0);
        checkValue("resetPush", 32'(bus.Push), 32'd0);
        Wresetn = 1'b1;
        @(posedge Wclk);
        #1;

        $display("[TB] single requester, six beats");
        remaining[2] = 6;
        nextData[2] = 3'd1;
        pushHist = '0;
        for (int c = 0; c < 10; c++) begin
            runCycle(1'b0);
            if (c < 8) pushHist = {pushHist[6:0], obsPush};
        end
        checkValue("singlePushPattern", 32'(pushHist), 32'b01111011);
        checkValue("singleFifoSize", dutFifo.size(), 6);
        for (int i = 0; i < 6 && i < dutFifo.size(); i++) begin
            checkValue("singleFifoData", 32'(dutFifo[i]), 32'(i + 1));
        end

        $display("[TB] four requesters, continuous rotation");
        doReset();
        for (int i = 0; i < NumReq; i++) remaining[i] = 100;
        runCycle(1'b0);
        for (int b = 0; b < 17; b++) begin
            runCycle(1'b0);
            checkValue("rotatePush", 32'(obsPush), 32'd1);
            checkValue("rotateOwner", 32'(obsOwner), 32'((b / MaxBurst) % NumReq));
        end
        clearRequests();
        for (int c = 0; c < 3; c++) runCycle(1'b0);

        $display("[TB] full stall mid-burst");
        doReset();
        remaining[1] = 4;
        nextData[1] = 3'd1;
        for (int c = 0; c < 3; c++) runCycle(1'b0);
        for (int c = 0; c < 3; c++) begin
            runCycle(1'b1);
            checkValue("stallPush", 32'(obsPush), 32'd0);
            checkValue("stallAck", 32'(obsAck), 32'd0);
            checkValue("stallGrant", 32'(obsGrant), 32'b0010);
        end
        for (int c = 0; c < 2; c++) begin
            runCycle(1'b0);
            checkValue("resumePush", 32'(obsPush), 32'd1);
        end
        runCycle(1'b0);
        checkValue("stallFifoSize", dutFifo.size(), 4);
        for (int i = 0; i < 4 && i < dutFifo.size(); i++) begin
            checkValue("stallFifoData", 32'(dutFifo[i]), 32'(i + 1));
        end

        $display("[TB] owner abandons after one beat");
        doReset();
        remaining[0] = 1;
        remaining[3] = 100;
        runCycle(1'b0);
        runCycle(1'b0);
        checkValue("abandonFirstBeat", 32'(obsGrant), 32'b0001);
        runCycle(1'b0);
        checkValue("abandonNoPush", 32'(obsPush), 32'd0);
        runCycle(1'b0);
        checkValue("abandonNewGrant", 32'(obsGrant), 32'b1000);
        checkValue("abandonLastOwner", 32'(dut.r_lastOwner), 32'd0);

        $display("[TB] asynchronous reset mid-burst");
        remaining[0] = 100;
        runCycle(1'b0);
        runCycle(1'b0);
        #2;
        Wresetn = 1'b0;
        #1;
        checkValue("asyncPush", 32'(bus.Push), 32'd0);
        checkValue("asyncAck", 32'(bus.Ack), 32'd0);
        checkValue("asyncGrant", 32'(bus.Grant), 32'd0);
        checkValue("asyncBusy", 32'(bus.Busy), 32'd0);
        modelReset();
        @(posedge Wclk);
        #2;
        checkValue("heldResetPush", 32'(bus.Push), 32'd0);
        Wresetn = 1'b1;
        runCycle(1'b0);
        runCycle(1'b0);
        checkValue("postResetGrant", 32'(obsGrant), 32'b0001);
        clearRequests();
        for (int c = 0; c < 3; c++) runCycle(1'b0);

        $display("[TB] randomized traffic");
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NumReq; i++) begin
                if (remaining[i] == 0) begin
                    if ($urandom_range(0, 99) < 40) begin
                        remaining[i] = $urandom_range(1, 7);
                        nextData[i]  = DataSize'($urandom);
                    end
                end else if ($urandom_range(0, 99) < 4) begin
                    remaining[i] = 0;
                end
            end
            runCycle($urandom_range(0, 99) < 25);
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end
endmodule
